// File: rtl/crc_pkg.sv
// Shared types for the CRC receive path: deserializer state encoding and frame sizing.
package crc_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_START,
        S_WAIT,
        S_OUT
    } deser_state_t;

    function automatic int frame_w(input int data_w, input int crc_w);
        return data_w + crc_w;
    endfunction

endpackage

// File: rtl/crc_frame_deserializer.sv
// Serial-to-parallel framing ahead of the sequential CRC verifier: collects {data, crc},
// hands the frame to the verifier and presents payload plus CRC status on valid/ready.
module crc_frame_deserializer
    import crc_pkg::*;
#(
    parameter int  DATA_WIDTH     = 12,
    parameter int  CRC_WIDTH      = 4,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int FRAME_W        = frame_w(DATA_WIDTH, CRC_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sin_valid,
    input  logic                  sin_bit,
    input  logic                  sin_sof,
    output logic                  sin_ready,
    output logic                  vfy_start,
    output logic [FRAME_W-1:0]    vfy_frame,
    input  logic                  vfy_done,
    input  logic                  vfy_crc_valid,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_crc_ok,
    output logic                  err_timeout,
    output logic                  err_resync
);

    localparam int                CNT_W     = $clog2(FRAME_W + 1);
    localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FRAME_W - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    deser_state_t          r_state;
    deser_state_t          w_state_nxt;
    logic [FRAME_W-1:0]    r_frame;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic                  r_sin_ready;
    logic                  r_m_valid;
    logic                  r_m_crc_ok;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_err_timeout;
    logic                  r_err_resync;

    logic w_accept;
    logic w_load;
    logic w_shift;
    logic w_timeout;
    logic w_resync;
    logic w_capture;
    logic w_start;

    assign w_accept = sin_valid & r_sin_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A sof always wins over completion and timeout: it restarts the frame in place.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_timeout   = 1'b0;
        w_resync    = 1'b0;
        w_capture   = 1'b0;
        w_start     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && sin_sof) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_accept && sin_sof) begin
                    w_load   = 1'b1;
                    w_resync = 1'b1;
                end else if (w_accept) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == CNT_LAST) begin
                        w_state_nxt = S_START;
                    end
                end else if (r_idle_cnt == IDLE_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_START: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (vfy_done) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (r_m_valid && m_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame    <= '0;
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
        end else begin
            if (w_load) begin
                r_frame   <= {{(FRAME_W-1){1'b0}}, sin_bit};
                r_bit_cnt <= CNT_W'(1);
            end else if (w_shift) begin
                r_frame   <= {r_frame[FRAME_W-2:0], sin_bit};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_timeout) begin
                r_bit_cnt <= '0;
            end

            if (r_state == S_SHIFT && !w_accept && !w_timeout) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= '0;
            end
        end
    end

    // sin_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sin_ready   <= 1'b0;
            r_m_valid     <= 1'b0;
            r_m_crc_ok    <= 1'b0;
            r_m_data      <= '0;
            r_err_timeout <= 1'b0;
            r_err_resync  <= 1'b0;
        end else begin
            r_sin_ready   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SHIFT);
            r_err_timeout <= w_timeout;
            r_err_resync  <= w_resync;
            if (w_capture) begin
                r_m_valid  <= 1'b1;
                r_m_crc_ok <= vfy_crc_valid;
                r_m_data   <= r_frame[FRAME_W-1:CRC_WIDTH];
            end else if (r_state == S_OUT && m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign sin_ready   = r_sin_ready;
    assign vfy_start   = w_start;
    assign vfy_frame   = r_frame;
    assign m_valid     = r_m_valid;
    assign m_data      = r_m_data;
    assign m_crc_ok    = r_m_crc_ok;
    assign err_timeout = r_err_timeout;
    assign err_resync  = r_err_resync;

endmodule

// File: tb/tb_crc_frame_deserializer.sv
// Directed bench for crc_frame_deserializer with an 18-cycle verifier stub and a
// scoreboard of expected frames consumed at vfy_start / m_valid.
module tb_crc_frame_deserializer;

    localparam int DW       = 12;
    localparam int CW       = 4;
    localparam int TO       = 64;
    localparam int FW       = DW + CW;
    localparam int STUB_LAT = 18;
    // vfy_start seen -> stub done after STUB_LAT edges -> captured one edge later
    localparam int MV_LAT   = STUB_LAT + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sin_valid = 1'b0;
    logic          sin_bit = 1'b0;
    logic          sin_sof = 1'b0;
    logic          sin_ready;
    logic          vfy_start;
    logic [FW-1:0] vfy_frame;
    logic          vfy_done = 1'b0;
    logic          vfy_crc_valid = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_crc_ok;
    logic          err_timeout;
    logic          err_resync;

    crc_frame_deserializer #(
        .DATA_WIDTH    (DW),
        .CRC_WIDTH     (CW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sin_valid    (sin_valid),
        .sin_bit      (sin_bit),
        .sin_sof      (sin_sof),
        .sin_ready    (sin_ready),
        .vfy_start    (vfy_start),
        .vfy_frame    (vfy_frame),
        .vfy_done     (vfy_done),
        .vfy_crc_valid(vfy_crc_valid),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_crc_ok     (m_crc_ok),
        .err_timeout  (err_timeout),
        .err_resync   (err_resync)
    );

    always #5 clk = ~clk;

    // Verifier stub: done is a level that stays high until the next start.
    logic stub_crc = 1'b1;
    int   stub_cnt = 0;
    always @(posedge clk) begin
        if (vfy_start) begin
            vfy_done <= 1'b0;
            stub_cnt <= STUB_LAT;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                vfy_done      <= 1'b1;
                vfy_crc_valid <= stub_crc;
            end
        end
    end

    int n_start = 0;
    int n_resync = 0;
    int n_timeout = 0;
    int n_mv = 0;
    always @(negedge clk) begin
        if (vfy_start)   n_start   <= n_start + 1;
        if (err_resync)  n_resync  <= n_resync + 1;
        if (err_timeout) n_timeout <= n_timeout + 1;
        if (m_valid)     n_mv      <= n_mv + 1;
    end

    typedef struct packed {
        logic [FW-1:0] frame;
        logic          crc_ok;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sof);
        int guard = 0;
        while (!sin_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!sin_ready) check("sin_ready_wait", 32'(sin_ready), 32'd1);
        sin_valid = 1'b1;
        sin_bit   = b;
        sin_sof   = sof;
        tick();
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
    endtask

    task automatic send_bits(input logic [FW-1:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i], i == n - 1);
    endtask

    task automatic send_frame(input logic [FW-1:0] val, input logic crc);
        exp_q.push_back('{frame: val, crc_ok: crc});
        send_bits(val, FW);
    endtask

    task automatic wait_start(input string tag);
        int guard = 0;
        while (!vfy_start && guard < 10) begin
            tick();
            guard++;
        end
        check({tag, "_start_lat"}, 32'(guard), 32'd0);
    endtask

    task automatic expect_output(input string tag);
        int   lat = 0;
        exp_t e;
        wait_start(tag);
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check({tag, "_frame"}, 32'(vfy_frame), 32'(e.frame));
        while (!m_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_mvalid_lat"}, 32'(lat), 32'(MV_LAT));
        check({tag, "_frame_held"}, 32'(vfy_frame), 32'(e.frame));
        check({tag, "_m_data"}, 32'(m_data), 32'(e.frame[FW-1:CW]));
        check({tag, "_m_crc_ok"}, 32'(m_crc_ok), 32'(e.crc_ok));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int r0;
        int t0;
        int mv0;

        repeat (3) tick();
        check("rst_sin_ready", 32'(sin_ready), 32'd0);
        check("rst_ctrl_outs", 32'({vfy_start, m_valid, m_crc_ok, err_timeout, err_resync}), 32'd0);
        check("rst_vfy_frame", 32'(vfy_frame), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_rst", 32'(sin_ready), 32'd1);

        // Nominal frame
        s0 = n_start;
        stub_crc = 1'b1;
        send_frame(16'h0013, 1'b1);
        expect_output("nom");
        tick();
        check("nom_m_valid_clr", 32'(m_valid), 32'd0);
        check("nom_ready_next", 32'(sin_ready), 32'd1);
        check("nom_one_start", 32'(n_start - s0), 32'd1);

        // Stale done: stub still holds done=1 with crc_valid=1 from the last frame
        stub_crc = 1'b0;
        send_frame(16'h0013, 1'b0);
        expect_output("stale");
        tick();

        // Resync mid-frame
        r0 = n_resync;
        t0 = n_timeout;
        stub_crc = 1'b1;
        send_bits(16'h0016, 5);
        send_frame(16'hABC5, 1'b1);
        expect_output("resync");
        tick();
        check("resync_pulses", 32'(n_resync - r0), 32'd1);
        check("resync_no_timeout", 32'(n_timeout - t0), 32'd0);

        // Inter-bit timeout
        t0 = n_timeout;
        s0 = n_start;
        send_bits(16'h005B, 7);
        repeat (TO - 1) tick();
        check("to_not_early", 32'(err_timeout), 32'd0);
        tick();
        check("to_pulse", 32'(err_timeout), 32'd1);
        check("to_ready_idle", 32'(sin_ready), 32'd1);
        tick();
        check("to_pulse_end", 32'(err_timeout), 32'd0);
        check("to_pulse_count", 32'(n_timeout - t0), 32'd1);
        check("to_no_start", 32'(n_start - s0), 32'd0);
        send_frame(16'h5A3C, 1'b1);
        expect_output("post_to");
        tick();

        // Output backpressure, with sof bits offered while the input is stalled
        r0 = n_resync;
        stub_crc = 1'b0;
        m_ready = 1'b0;
        send_frame(16'h7E1D, 1'b0);
        expect_output("bp");
        sin_valid = 1'b1;
        sin_sof   = 1'b1;
        sin_bit   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold", 32'({m_valid, sin_ready, m_data, m_crc_ok}),
                  32'({1'b1, 1'b0, 12'h7E1, 1'b0}));
        end
        sin_valid = 1'b0;
        sin_sof   = 1'b0;
        m_ready   = 1'b1;
        tick();
        check("bp_m_valid_clr", 32'(m_valid), 32'd0);
        check("bp_ready_next", 32'(sin_ready), 32'd1);
        check("bp_no_resync", 32'(n_resync - r0), 32'd0);

        // Reset while waiting on the verifier
        stub_crc = 1'b1;
        send_frame(16'h1234, 1'b1);
        wait_start("rstw");
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rstw_ctrl_outs", 32'({sin_ready, vfy_start, m_valid, m_crc_ok, err_timeout, err_resync}), 32'd0);
        check("rstw_vfy_frame", 32'(vfy_frame), 32'd0);
        check("rstw_m_data", 32'(m_data), 32'd0);
        void'(exp_q.pop_back());
        mv0 = n_mv;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (30) tick();
        check("rstw_no_m_valid", 32'(n_mv - mv0), 32'd0);
        check("rstw_ready", 32'(sin_ready), 32'd1);

        send_frame(16'hC3F6, 1'b1);
        expect_output("final");
        tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
